// File: rtl/song_sequencer_pkg.sv
// Shared definitions for the song sequencer: state encoding, ROM word layout,
// default widths and field-extraction helpers.
package song_sequencer_pkg;

    localparam int DEF_SONG_BITS = 2;
    localparam int DEF_IDX_BITS  = 5;
    localparam int DEF_NOTE_W    = 6;
    localparam int DEF_DUR_W     = 6;

    localparam int NOTE_MSB = 11;
    localparam int NOTE_LSB = 6;
    localparam int DUR_MSB  = 5;
    localparam int DUR_LSB  = 0;

    localparam logic [DEF_NOTE_W-1:0] NOTE_REST = 6'd0;
    localparam logic [DEF_DUR_W-1:0]  DUR_END   = 6'd0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        PLAY  = 3'd3,
        DONE  = 3'd4
    } state_t;

    function automatic logic [DEF_NOTE_W-1:0] rom_note(input logic [NOTE_MSB:0] word);
        return word[NOTE_MSB:NOTE_LSB];
    endfunction

    function automatic logic [DEF_DUR_W-1:0] rom_dur(input logic [NOTE_MSB:0] word);
        return word[DUR_MSB:DUR_LSB];
    endfunction

endpackage

// File: rtl/song_sequencer_if.sv
// Control, ROM and player-facing signals of the song sequencer.
// master = user control plus song ROM side, slave = the sequencer.
interface song_sequencer_if #(
    parameter int SONG_BITS = song_sequencer_pkg::DEF_SONG_BITS,
    parameter int IDX_BITS  = song_sequencer_pkg::DEF_IDX_BITS,
    parameter int NOTE_W    = song_sequencer_pkg::DEF_NOTE_W,
    parameter int DUR_W     = song_sequencer_pkg::DEF_DUR_W
);
    logic                          play;
    logic                          restart;
    logic [SONG_BITS-1:0]          song_sel;
    logic                          beat;
    logic [SONG_BITS+IDX_BITS-1:0] rom_addr;
    logic [NOTE_W+DUR_W-1:0]       rom_dout;
    logic [NOTE_W-1:0]             note_out;
    logic                          new_note;
    logic                          playing;
    logic                          song_done;
    logic [IDX_BITS-1:0]           idx_out;

    modport master (
        output play, restart, song_sel, beat, rom_dout,
        input  rom_addr, note_out, new_note, playing, song_done, idx_out
    );

    modport slave (
        input  play, restart, song_sel, beat, rom_dout,
        output rom_addr, note_out, new_note, playing, song_done, idx_out
    );
endinterface

// File: rtl/song_sequencer_note_timer.sv
// Beat-driven duration counter: loads a note length, counts beats down while
// enabled and flags the beat that ends the note.
module note_timer
    import song_sequencer_pkg::*;
#(
    parameter int DUR_W = DEF_DUR_W
)(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             load,
    input  logic [DUR_W-1:0] load_val,
    input  logic             enable,
    input  logic             beat,
    output logic             expire
);
    localparam logic [DUR_W-1:0] DUR_ONE  = {{(DUR_W-1){1'b0}}, 1'b1};
    localparam logic [DUR_W-1:0] DUR_ZERO = {DUR_W{1'b0}};

    logic [DUR_W-1:0] dur_cnt_r;

    assign expire = enable && beat && (dur_cnt_r == DUR_ONE);

    // Duration counter: clear beats load, a frozen count holds while disabled.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dur_cnt_r <= DUR_ZERO;
        end else if (clear) begin
            dur_cnt_r <= DUR_ZERO;
        end else if (load) begin
            dur_cnt_r <= load_val;
        end else if (enable && beat) begin
            if (dur_cnt_r > DUR_ONE) begin
                dur_cnt_r <= dur_cnt_r - DUR_ONE;
            end else begin
                dur_cnt_r <= DUR_ZERO;
            end
        end else begin
            dur_cnt_r <= dur_cnt_r;
        end
    end
endmodule

// File: rtl/song_sequencer.sv
// Song sequencer: walks one song of the note ROM, absorbs the ROM read latency
// and holds each note for its duration in beats; play/pause, restart, end-of-song.
module song_sequencer
    import song_sequencer_pkg::*;
#(
    parameter int SONG_BITS = DEF_SONG_BITS,
    parameter int IDX_BITS  = DEF_IDX_BITS,
    parameter int NOTE_W    = DEF_NOTE_W,
    parameter int DUR_W     = DEF_DUR_W
)(
    input  logic           clk,
    input  logic           reset_n,
    song_sequencer_if.slave bus
);
    localparam logic [IDX_BITS-1:0]  IDX_ZERO  = {IDX_BITS{1'b0}};
    localparam logic [IDX_BITS-1:0]  IDX_ONE   = {{(IDX_BITS-1){1'b0}}, 1'b1};
    localparam logic [IDX_BITS-1:0]  IDX_MAX   = {IDX_BITS{1'b1}};
    localparam logic [SONG_BITS-1:0] SONG_ZERO = {SONG_BITS{1'b0}};
    localparam logic [NOTE_W-1:0]    NOTE_ZERO = {NOTE_W{1'b0}};

    state_t                state_r;
    logic [SONG_BITS-1:0]  song_r;
    logic [IDX_BITS-1:0]   idx_r;
    logic [NOTE_W-1:0]     note_out_r;
    logic                  new_note_r;
    logic                  playing_r;
    logic                  song_done_r;

    logic [NOTE_W-1:0]     rom_note_s;
    logic [DUR_W-1:0]      rom_dur_s;
    logic                  load_s;
    logic                  enable_s;
    logic                  expire_s;

    assign rom_note_s = rom_note(bus.rom_dout);
    assign rom_dur_s  = rom_dur(bus.rom_dout);

    // Timer only loads a real note and only counts in PLAY while playing; restart overrides both.
    assign load_s   = (state_r == WAIT) && !bus.restart && (rom_dur_s != DUR_END);
    assign enable_s = (state_r == PLAY) && bus.play && !bus.restart;

    note_timer #(.DUR_W(DUR_W)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (bus.restart),
        .load     (load_s),
        .load_val (rom_dur_s),
        .enable   (enable_s),
        .beat     (bus.beat),
        .expire   (expire_s)
    );

    // Sequencer FSM with registered player outputs; new_note/song_done are single-cycle pulses.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            song_r      <= SONG_ZERO;
            idx_r       <= IDX_ZERO;
            note_out_r  <= NOTE_ZERO;
            new_note_r  <= 1'b0;
            playing_r   <= 1'b0;
            song_done_r <= 1'b0;
        end else begin
            new_note_r  <= 1'b0;
            song_done_r <= 1'b0;
            if (bus.restart) begin
                state_r    <= IDLE;
                idx_r      <= IDX_ZERO;
                note_out_r <= NOTE_ZERO;
                playing_r  <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        playing_r <= 1'b0;
                        if (bus.play) begin
                            state_r <= FETCH;
                            song_r  <= bus.song_sel;
                            idx_r   <= IDX_ZERO;
                        end
                    end
                    FETCH: begin
                        playing_r <= 1'b0;
                        state_r   <= WAIT;
                    end
                    WAIT: begin
                        if (rom_dur_s == DUR_END) begin
                            state_r     <= DONE;
                            song_done_r <= 1'b1;
                            note_out_r  <= NOTE_REST;
                            playing_r   <= 1'b0;
                        end else begin
                            state_r    <= PLAY;
                            note_out_r <= rom_note_s;
                            new_note_r <= 1'b1;
                            playing_r  <= bus.play;
                        end
                    end
                    PLAY: begin
                        if (expire_s) begin
                            playing_r <= 1'b0;
                            // The last slot of a song always ends the song; the index never wraps.
                            if (idx_r == IDX_MAX) begin
                                state_r     <= DONE;
                                song_done_r <= 1'b1;
                                note_out_r  <= NOTE_REST;
                            end else begin
                                state_r <= FETCH;
                                idx_r   <= idx_r + IDX_ONE;
                            end
                        end else begin
                            playing_r <= bus.play;
                        end
                    end
                    DONE: begin
                        note_out_r <= NOTE_REST;
                        playing_r  <= 1'b0;
                        if (!bus.play) begin
                            state_r <= IDLE;
                            idx_r   <= IDX_ZERO;
                        end
                    end
                    default: begin
                        state_r    <= IDLE;
                        idx_r      <= IDX_ZERO;
                        note_out_r <= NOTE_ZERO;
                        playing_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.rom_addr  = {song_r, idx_r};
    assign bus.note_out  = note_out_r;
    assign bus.new_note  = new_note_r;
    assign bus.playing   = playing_r;
    assign bus.song_done = song_done_r;
    assign bus.idx_out   = idx_r;
endmodule

// File: tb/tb_song_sequencer.sv
// Self-checking bench for song_sequencer: registered song ROM model, randomized
// beat/gap stimulus, expectations derived from the song table contents.
module tb_song_sequencer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    song_sequencer_if bus();
    song_sequencer dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    logic [11:0] rom_mem [0:127];
    always @(posedge clk) bus.rom_dout <= rom_mem[bus.rom_addr];

    int total = 0;
    int bad = 0;

    task automatic step(input logic b);
        bus.beat = b;
        @(posedge clk);
        #1;
        bus.beat = 1'b0;
    endtask

    task automatic go_idle();
        bus.play = 1'b0;
        bus.restart = 1'b1;
        step(1'b0);
        bus.restart = 1'b0;
        step(1'b0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step(1'b0);
        step(1'b0);
        total++; if (bus.note_out !== 6'd0) begin bad++; $display("FAIL reset_note got=%0d exp=0", bus.note_out); end
        total++; if (bus.new_note !== 1'b0) begin bad++; $display("FAIL reset_new_note got=%b exp=0", bus.new_note); end
        total++; if (bus.playing !== 1'b0) begin bad++; $display("FAIL reset_playing got=%b exp=0", bus.playing); end
        total++; if (bus.song_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.song_done); end
        total++; if (bus.idx_out !== 5'd0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", bus.idx_out); end
        reset_n = 1'b1;
        step(1'b0);
        total++; if (bus.rom_addr !== 7'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", bus.rom_addr); end
    endtask

    task automatic test_first_note();
        bus.song_sel = 2'd1;
        bus.play = 1'b1;
        step(1'b0);
        total++; if (bus.rom_addr !== 7'd32) begin bad++; $display("FAIL t1_fetch_addr got=%0d exp=32", bus.rom_addr); end
        step(1'b0);
        total++; if (bus.new_note !== 1'b0) begin bad++; $display("FAIL t1_early_new_note got=%b exp=0", bus.new_note); end
        step(1'b0);
        total++; if (bus.note_out !== 6'd35 || bus.new_note !== 1'b1 || bus.playing !== 1'b1)
            begin bad++; $display("FAIL t1_first_note got note=%0d nn=%b pl=%b exp 35/1/1", bus.note_out, bus.new_note, bus.playing); end
        for (int i = 1; i <= 35; i++) begin
            if ($urandom_range(0, 1) == 1) step(1'b0);
            step(1'b1);
        end
        total++; if (bus.rom_addr !== 7'd32) begin bad++; $display("FAIL t1_early_advance got=%0d exp=32", bus.rom_addr); end
        step(1'b1);
        total++; if (bus.rom_addr !== 7'd33 || bus.note_out !== 6'd35)
            begin bad++; $display("FAIL t1_advance got addr=%0d note=%0d exp 33/35", bus.rom_addr, bus.note_out); end
        step(1'b0);
        step(1'b0);
        total++; if (bus.note_out !== 6'd42 || bus.new_note !== 1'b1 || bus.idx_out !== 5'd1)
            begin bad++; $display("FAIL t1_second_note got note=%0d nn=%b idx=%0d exp 42/1/1", bus.note_out, bus.new_note, bus.idx_out); end
        go_idle();
    endtask

    // Plays song s from IDLE and checks every entry against the table until it ends.
    task automatic run_song(input int s);
        int idx = 0;
        bit fin = 1'b0;
        int addr, d, n, waitc;
        bus.song_sel = 2'(s);
        bus.play = 1'b1;
        while (!fin) begin
            addr = s * 32 + idx;
            d = int'(rom_mem[addr][5:0]);
            n = int'(rom_mem[addr][11:6]);
            waitc = 0;
            while (bus.new_note !== 1'b1 && bus.song_done !== 1'b1 && waitc < 8) begin
                step(1'($urandom_range(0, 1)));
                waitc++;
            end
            total++;
            if (waitc >= 8 || (waitc != 2 && idx != 0) || (waitc != 3 && idx == 0)) begin
                bad++; $display("FAIL song%0d_latency idx=%0d got=%0d cycles", s, idx, waitc);
                fin = 1'b1;
            end else if (d == 0) begin
                total++;
                if (bus.song_done !== 1'b1 || bus.new_note !== 1'b0 || bus.note_out !== 6'd0 || bus.idx_out !== 5'(idx))
                    begin bad++; $display("FAIL song%0d_marker idx=%0d got done=%b nn=%b note=%0d", s, idx, bus.song_done, bus.new_note, bus.note_out); end
                fin = 1'b1;
            end else begin
                total++;
                if (bus.new_note !== 1'b1 || bus.note_out !== 6'(n) || bus.idx_out !== 5'(idx))
                    begin bad++; $display("FAIL song%0d_note idx=%0d got note=%0d nn=%b i=%0d exp note=%0d", s, idx, bus.note_out, bus.new_note, bus.idx_out, n); end
                for (int b = 1; b <= d; b++) begin
                    repeat ($urandom_range(0, 2)) step(1'b0);
                    step(1'b1);
                end
                if (idx == 31) begin
                    total++;
                    if (bus.song_done !== 1'b1 || bus.note_out !== 6'd0)
                        begin bad++; $display("FAIL song%0d_last_done got done=%b note=%0d exp 1/0", s, bus.song_done, bus.note_out); end
                    fin = 1'b1;
                end else begin
                    idx++;
                    total++;
                    if (bus.rom_addr !== 7'(s * 32 + idx) || bus.song_done !== 1'b0)
                        begin bad++; $display("FAIL song%0d_next_addr got=%0d exp=%0d", s, bus.rom_addr, s * 32 + idx); end
                end
            end
        end
    endtask

    task automatic test_end_marker();
        run_song(0);
        step(1'b1);
        total++; if (bus.idx_out !== 5'd28 || bus.song_done !== 1'b0 || bus.playing !== 1'b0 || bus.note_out !== 6'd0)
            begin bad++; $display("FAIL t2_done_hold got idx=%0d done=%b pl=%b note=%0d", bus.idx_out, bus.song_done, bus.playing, bus.note_out); end
        bus.play = 1'b0;
        step(1'b0);
        total++; if (bus.idx_out !== 5'd0) begin bad++; $display("FAIL t2_release_idx got=%0d exp=0", bus.idx_out); end
        go_idle();
    endtask

    task automatic test_pause();
        bus.song_sel = 2'd1;
        bus.play = 1'b1;
        repeat (3) step(1'b0);
        for (int i = 0; i < 10; i++) step(1'b1);
        bus.play = 1'b0;
        bus.song_sel = 2'd2;
        for (int i = 0; i < 50; i++) begin
            if ($urandom_range(0, 1) == 1) step(1'b0);
            step(1'b1);
        end
        total++; if (bus.note_out !== 6'd35 || bus.playing !== 1'b0 || bus.rom_addr !== 7'd32 || bus.new_note !== 1'b0)
            begin bad++; $display("FAIL t3_paused got note=%0d pl=%b addr=%0d", bus.note_out, bus.playing, bus.rom_addr); end
        bus.play = 1'b1;
        for (int i = 0; i < 25; i++) step(1'b1);
        total++; if (bus.rom_addr !== 7'd32 || bus.playing !== 1'b1)
            begin bad++; $display("FAIL t3_resume_early got addr=%0d pl=%b exp 32/1", bus.rom_addr, bus.playing); end
        step(1'b1);
        total++; if (bus.rom_addr !== 7'd33) begin bad++; $display("FAIL t3_resume_advance got=%0d exp=33", bus.rom_addr); end
        go_idle();
    endtask

    task automatic test_last_entry();
        int extra = 0;
        run_song(3);
        for (int i = 0; i < 6; i++) begin
            step(1'($urandom_range(0, 1)));
            if (bus.rom_addr !== 7'd127 || bus.new_note !== 1'b0 || bus.song_done !== 1'b0) extra++;
        end
        total++; if (extra !== 0) begin bad++; $display("FAIL t4_no_wrap got=%0d bad cycles exp=0", extra); end
        go_idle();
    endtask

    task automatic test_restart();
        int events = 0;
        bus.song_sel = 2'd1;
        bus.play = 1'b1;
        repeat (3) step(1'b0);
        for (int i = 0; i < 35; i++) step(1'b1);
        bus.restart = 1'b1;
        step(1'b1);
        bus.restart = 1'b0;
        bus.play = 1'b0;
        total++; if (bus.idx_out !== 5'd0 || bus.note_out !== 6'd0 || bus.new_note !== 1'b0 || bus.song_done !== 1'b0 || bus.playing !== 1'b0)
            begin bad++; $display("FAIL t5_restart got idx=%0d note=%0d nn=%b done=%b", bus.idx_out, bus.note_out, bus.new_note, bus.song_done); end
        for (int i = 0; i < 4; i++) begin
            step(1'b1);
            if (bus.new_note !== 1'b0 || bus.song_done !== 1'b0 || bus.idx_out !== 5'd0) events++;
        end
        total++; if (events !== 0) begin bad++; $display("FAIL t5_quiet got=%0d events exp=0", events); end
    endtask

    task automatic test_reset_mid();
        bus.song_sel = 2'd2;
        bus.play = 1'b1;
        repeat (3) step(1'b0);
        total++; if (bus.new_note !== 1'b1 || bus.note_out !== 6'(rom_mem[64][11:6]))
            begin bad++; $display("FAIL t6_play got nn=%b note=%0d", bus.new_note, bus.note_out); end
        reset_n = 1'b0;
        step(1'b1);
        total++; if (bus.note_out !== 6'd0 || bus.playing !== 1'b0 || bus.idx_out !== 5'd0 || bus.rom_addr !== 7'd0 || bus.new_note !== 1'b0 || bus.song_done !== 1'b0)
            begin bad++; $display("FAIL t6_reset_play got note=%0d pl=%b addr=%0d", bus.note_out, bus.playing, bus.rom_addr); end
        reset_n = 1'b1;
        step(1'b0);
        total++; if (bus.rom_addr !== 7'd64) begin bad++; $display("FAIL t6_refetch got=%0d exp=64", bus.rom_addr); end
        step(1'b0);
        reset_n = 1'b0;
        bus.song_sel = 2'd3;
        step(1'b0);
        total++; if (bus.note_out !== 6'd0 || bus.new_note !== 1'b0 || bus.rom_addr !== 7'd0)
            begin bad++; $display("FAIL t6_reset_wait got note=%0d nn=%b addr=%0d", bus.note_out, bus.new_note, bus.rom_addr); end
        reset_n = 1'b1;
        step(1'b0);
        total++; if (bus.rom_addr !== 7'd96) begin bad++; $display("FAIL t6_new_song got=%0d exp=96", bus.rom_addr); end
        step(1'b0);
        step(1'b0);
        total++; if (bus.new_note !== 1'b1 || bus.note_out !== 6'(rom_mem[96][11:6]))
            begin bad++; $display("FAIL t6_first_note got nn=%b note=%0d", bus.new_note, bus.note_out); end
        go_idle();
    endtask

    initial begin
        for (int a = 0; a < 128; a++) rom_mem[a] = {6'((a * 7 + 3) % 64), 6'((a % 3) + 1)};
        rom_mem[32]  = {6'd35, 6'd36};
        rom_mem[33]  = {6'd42, 6'd2};
        rom_mem[28]  = {6'd37, 6'd0};
        rom_mem[98]  = {6'd0, 6'd2};
        rom_mem[127] = {6'd20, 6'd6};
        bus.play = 1'b0;
        bus.restart = 1'b0;
        bus.beat = 1'b0;
        bus.song_sel = 2'd0;
        test_reset();
        test_first_note();
        test_end_marker();
        test_pause();
        test_last_entry();
        test_restart();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
